// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a common-anode seven-segment display.
// It scans one digit per refresh slot and blanks the start of each slot to stop ghosting.
module sevenseg_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_blank,
    input  logic                  update,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            sevenseg,
    output logic                  dp
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W:0]   BLANK_LIM = (PRE_W + 1)'(BLANK_CYCLES);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] val_sh_q, val_sh_d;
    logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]   en_sh_q, en_sh_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic [N_DIGITS-1:0]   sel_s;
    logic [N_DIGITS-1:0]   vis_s;
    logic [3:0]            nib_s;
    logic                  vis_cur_s;
    logic                  dp_cur_s;
    logic                  lz_run_s;
    logic                  blank_s;

    // Prescaler wrap advances the slot index; every digit gets a slot even when disabled
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRE_MAX) begin
            presc_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    // Shadow registers load only on the update strobe
    always_comb begin
        val_sh_d = val_sh_q;
        dp_sh_d  = dp_sh_q;
        en_sh_d  = en_sh_q;
        if (update) begin
            val_sh_d = value;
            dp_sh_d  = dp_in;
            en_sh_d  = digit_en;
        end else begin
            val_sh_d = val_sh_q;
            dp_sh_d  = dp_sh_q;
            en_sh_d  = en_sh_q;
        end
    end

    // Zero run scanned from the most significant digit down decides leading-zero suppression
    always_comb begin
        sel_s     = '0;
        vis_s     = '0;
        nib_s     = 4'h0;
        vis_cur_s = 1'b0;
        dp_cur_s  = 1'b0;
        lz_run_s  = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            lz_run_s = lz_run_s & (val_sh_q[4*k +: 4] == 4'h0);
            vis_s[k] = en_sh_q[k] & ~(lz_blank & lz_run_s & (k != 0));
            sel_s[k] = (idx_q == IDX_W'(k));
        end
        for (int k = 0; k < N_DIGITS; k++) begin
            nib_s     = nib_s | (val_sh_q[4*k +: 4] & {4{sel_s[k]}});
            vis_cur_s = vis_cur_s | (vis_s[k] & sel_s[k]);
            dp_cur_s  = dp_cur_s | (dp_sh_q[k] & sel_s[k]);
        end
    end

    // Next output pattern for the current (slot, prescaler) position
    always_comb begin
        an_d    = '1;
        seg_d   = 7'b1111111;
        dp_d    = 1'b1;
        blank_s = ({1'b0, presc_q} < BLANK_LIM);
        if (!blank_s && vis_cur_s) begin
            an_d  = ~sel_s;
            seg_d = hex7(nib_s);
            dp_d  = ~dp_cur_s;
        end else begin
            an_d  = '1;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            val_sh_q <= '0;
            dp_sh_q  <= '0;
            en_sh_q  <= '0;
            an_q     <= '1;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            val_sh_q <= val_sh_d;
            dp_sh_q  <= dp_sh_d;
            en_sh_q  <= en_sh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an       = an_q;
    assign sevenseg = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        update;
    logic [3:0]  an;
    logic [6:0]  sevenseg;
    logic        dp;

    int total = 0;
    int bad   = 0;
    int cyc;

    localparam logic [6:0] DK = 7'b1111111;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dpi;
        logic [3:0]      en;
        logic            lz;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } vec_t;

    vec_t vecs [9];

    sevenseg_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .lz_blank(lz_blank), .update(update),
        .an(an), .sevenseg(sevenseg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Counts edges since reset release; the sample after edge n reflects scan state n-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(string nm, logic [3:0] ea, logic [6:0] es, logic ed);
        total++;
        if (an !== ea || sevenseg !== es || dp !== ed) begin
            bad++;
            $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     nm, cyc, an, sevenseg, dp, ea, es, ed);
        end
    endtask

    task automatic chk_vec(string nm, int v);
        int s, k, p;
        s = cyc - 1;
        k = (s / 4) % 4;
        p = s % 4;
        if (p < 1 || vecs[v].seg[k] == DK)
            chk(nm, 4'b1111, DK, 1'b1);
        else
            chk(nm, 4'b1111 & ~(4'b0001 << k), vecs[v].seg[k], vecs[v].dpo[k]);
    endtask

    task automatic align(int ph);
        for (int t = 0; t < 20 && (cyc % 16) != ph; t++) @(negedge clk);
        total++;
        if ((cyc % 16) != ph) begin
            bad++;
            $display("FAIL align: phase %0d, want %0d", cyc % 16, ph);
        end
    endtask

    task automatic scan_vec(string nm, int v);
        align(1);
        for (int i = 0; i < 16; i++) begin
            chk_vec(nm, v);
            @(negedge clk);
        end
    endtask

    task automatic apply_vec(int v);
        value    = vecs[v].value;
        dp_in    = vecs[v].dpi;
        digit_en = vecs[v].en;
        lz_blank = vecs[v].lz;
        update   = 1'b1;
        @(negedge clk);
        update   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0100, 4'hF, 1'b0,
                    {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1011};
        vecs[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1,
                    {DK, DK, 7'b0100100, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1,
                    {DK, DK, DK, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'h8888, 4'b0000, 4'b0101, 1'b0,
                    {DK, 7'b0000000, DK, 7'b0000000}, 4'b1111};
        vecs[4] = '{16'h0050, 4'b1111, 4'hF, 1'b1,
                    {DK, DK, 7'b0100100, 7'b0000001}, 4'b1100};
        vecs[5] = '{16'h0123, 4'b0000, 4'hF, 1'b0,
                    {7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110}, 4'b1111};
        vecs[6] = '{16'hC0DE, 4'b1000, 4'hF, 1'b1,
                    {7'b0110001, 7'b0000001, 7'b1000010, 7'b0110000}, 4'b0111};
        vecs[7] = '{16'h9B47, 4'b0001, 4'hF, 1'b0,
                    {7'b0001100, 7'b1100000, 7'b1001100, 7'b0001111}, 4'b1110};
        vecs[8] = '{16'h0100, 4'b0010, 4'hF, 1'b1,
                    {DK, 7'b1001111, 7'b0000001, 7'b0000001}, 4'b1101};

        rst_n = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'h0;
        lz_blank = 1'b0; update = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'b1111 || sevenseg !== DK || dp !== 1'b1) begin
            bad++;
            $display("FAIL reset: an=%b seg=%b dp=%b, want 1111 1111111 1", an, sevenseg, dp);
        end
        rst_n = 1'b1;

        // Idle: no update yet, display stays dark even with inputs present
        value = 16'hFFFF; digit_en = 4'hF;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("idle", 4'b1111, DK, 1'b1);
        end

        for (int v = 0; v < 9; v++) begin
            apply_vec(v);
            scan_vec($sformatf("vec%0d", v), v);
        end

        // Value changes without update must not reach the display
        value = 16'h5555; digit_en = 4'h0; dp_in = 4'hF;
        scan_vec("no_update", 8);

        // Update strobe on the slot-wrap edge: next slot shows new data after its blank cycle
        align(3);
        value = 16'h6666; dp_in = 4'h0; digit_en = 4'hF; lz_blank = 1'b0; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("wrap_old", 4'b1110, 7'b0000001, 1'b1);
        @(negedge clk);
        chk("wrap_blank", 4'b1111, DK, 1'b1);
        @(negedge clk);
        chk("wrap_new", 4'b1101, 7'b0100000, 1'b1);

        // Asynchronous reset while digit 2 is lit
        for (int t = 0; t < 20 && an !== 4'b1011; t++) @(negedge clk);
        chk("pre_rst", 4'b1011, 7'b0100000, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 4'b1111, DK, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("post_rst_dark", 4'b1111, DK, 1'b1);
        end
        apply_vec(0);
        scan_vec("post_rst_scan", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
